// File: rtl/key_conditioner.sv
// key_conditioner: cleans up board push-buttons and DIP switches for the processor.
//   Every key passes through a 2-FF synchronizer, a counter debouncer and a press-edge
//   pulse FSM. Keys set in REPEAT_MASK also auto-repeat while they are held.
//   The DIP word is only synchronized; it is not debounced.
// Ports:
//   clk_i        system clock; all state changes on the rising edge
//   rst_i        synchronous, active-high reset
//   key_raw_i    asynchronous button pins, 1 = pressed
//   dip_raw_i    asynchronous switch pins
//   key_pulse_o  one-cycle strobe for each accepted press or auto-repeat
//   key_level_o  debounced held level
//   dip_sync_o   2-FF synchronized switch word
module key_conditioner #(
   parameter int unsigned          NUM_KEYS        = 5,
   parameter int unsigned          DIP_W           = 16,
   parameter int unsigned          DEBOUNCE_CYCLES = 50000,
   parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = 5'b00101,
   parameter int unsigned          REPEAT_DELAY    = 25000000,
   parameter int unsigned          REPEAT_RATE     = 5000000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_KEYS-1:0] key_raw_i,
   input  logic [DIP_W-1:0]    dip_raw_i,
   output logic [NUM_KEYS-1:0] key_pulse_o,
   output logic [NUM_KEYS-1:0] key_level_o,
   output logic [DIP_W-1:0]    dip_sync_o
);

   localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RMax  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RcntW = (RMax > 1) ? $clog2(RMax) : 1;

   localparam logic [CntW-1:0]  CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RcntW-1:0] DelayLast = RcntW'(REPEAT_DELAY - 1);
   localparam logic [RcntW-1:0] RateLast  = RcntW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat} key_st_e;

   logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
   logic [DIP_W-1:0]    dip_s1_q, dip_s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         key_s1_q <= '0;
         key_s2_q <= '0;
         dip_s1_q <= '0;
         dip_s2_q <= '0;
      end else begin
         key_s1_q <= key_raw_i;
         key_s2_q <= key_s1_q;
         dip_s1_q <= dip_raw_i;
         dip_s2_q <= dip_s1_q;
      end
   end

   assign dip_sync_o = dip_s2_q;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      localparam bit Masked = REPEAT_MASK[i];

      logic [CntW-1:0]  cnt_q, cnt_d;
      logic             stable_q, stable_d;
      logic             rise, fall;
      key_st_e          state_q, state_d;
      logic [RcntW-1:0] rcnt_q, rcnt_d;
      logic             pulse_q, pulse_d;

      // Debouncer: a new level is accepted only after DEBOUNCE_CYCLES disagreeing samples
      // in a row; any agreeing sample restarts the count.
      always_comb begin
         cnt_d    = cnt_q;
         stable_d = stable_q;
         if (key_s2_q[i] == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CntLast) begin
            stable_d = key_s2_q[i];
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Edge events are taken from the accept decision so the press pulse and the new
      // level become visible on the same clock edge.
      assign rise = ~stable_q & stable_d;
      assign fall = stable_q & ~stable_d;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            state_q  <= StIdle;
            rcnt_q   <= '0;
            pulse_q  <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            pulse_q  <= pulse_d;
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            StIdle: begin
               if (rise) state_d = StHold;
            end
            StHold: begin
               if (fall) begin
                  state_d = StIdle;
               end else if (Masked && (rcnt_q == DelayLast)) begin
                  state_d = StRepeat;
               end
            end
            StRepeat: begin
               if (fall) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Release always wins over a coinciding repeat match, so release never pulses.
      always_comb begin
         pulse_d = 1'b0;
         rcnt_d  = '0;
         unique case (state_q)
            StIdle: begin
               pulse_d = rise;
            end
            StHold: begin
               if (!fall && Masked) begin
                  if (rcnt_q == DelayLast) pulse_d = 1'b1;
                  else                     rcnt_d  = rcnt_q + 1'b1;
               end
            end
            StRepeat: begin
               if (!fall) begin
                  if (rcnt_q == RateLast) pulse_d = 1'b1;
                  else                    rcnt_d  = rcnt_q + 1'b1;
               end
            end
            default: begin
               pulse_d = 1'b0;
               rcnt_d  = '0;
            end
         endcase
      end

      assign key_pulse_o[i] = pulse_q;
      assign key_level_o[i] = stable_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios followed by random
// bouncing keys, DIP changes and occasional resets, compared every cycle against
// a history-window reference model.
module tb_key_conditioner;

   localparam int unsigned NK    = 5;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEB   = 4;
   localparam int unsigned DELAY = 10;
   localparam int unsigned RATE  = 3;
   localparam logic [NK-1:0] MASK = 5'b00101;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_raw;
   logic [DW-1:0] dip_raw;
   logic [NK-1:0] key_pulse, key_level;
   logic [DW-1:0] dip_sync;

   always #5 clk = ~clk;

   key_conditioner #(
      .NUM_KEYS       (NK),
      .DIP_W          (DW),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_MASK    (MASK),
      .REPEAT_DELAY   (DELAY),
      .REPEAT_RATE    (RATE)
   ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .key_raw_i  (key_raw),
      .dip_raw_i  (dip_raw),
      .key_pulse_o(key_pulse),
      .key_level_o(key_level),
      .dip_sync_o (dip_sync)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int edge_no  = 0;
   int pcnt[NK];

   // Reference model state
   logic [NK-1:0] raw_hist[$];
   logic [NK-1:0] deb_hist[$];
   logic [DW-1:0] dip_hist[$];
   logic [NK-1:0] exp_level, exp_pulse;
   logic [DW-1:0] exp_dip;
   int            press_t[NK];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_no, got, exp);
   endtask

   // Level flips when the last DEB synchronized samples all disagree with it; a held
   // key pulses at the press and then DELAY, DELAY+RATE, ... edges later.
   task automatic model_edge();
      logic [NK-1:0] samp, nl;
      bit            all_diff;
      int            dt;
      edge_no++;
      if (rst) begin
         raw_hist.delete();
         raw_hist.push_back('0);
         raw_hist.push_back('0);
         deb_hist.delete();
         dip_hist.delete();
         dip_hist.push_back('0);
         exp_level = '0;
         exp_pulse = '0;
         exp_dip   = '0;
      end else begin
         samp = raw_hist[raw_hist.size()-2];
         raw_hist.push_back(key_raw);
         if (raw_hist.size() > 8) void'(raw_hist.pop_front());
         deb_hist.push_back(samp);
         if (deb_hist.size() > 16) void'(deb_hist.pop_front());
         nl = exp_level;
         for (int i = 0; i < NK; i++) begin
            if (deb_hist.size() >= DEB) begin
               all_diff = 1'b1;
               for (int j = 0; j < DEB; j++)
                  if (deb_hist[deb_hist.size()-1-j][i] == exp_level[i]) all_diff = 1'b0;
               if (all_diff) nl[i] = ~exp_level[i];
            end
         end
         for (int i = 0; i < NK; i++) begin
            if (nl[i] && !exp_level[i]) press_t[i] = edge_no;
            dt = edge_no - press_t[i];
            exp_pulse[i] = nl[i] && ((dt == 0) ||
                           (MASK[i] && dt >= DELAY && ((dt - DELAY) % RATE) == 0));
         end
         exp_level = nl;
         exp_dip   = dip_hist[dip_hist.size()-1];
         dip_hist.push_back(dip_raw);
         if (dip_hist.size() > 4) void'(dip_hist.pop_front());
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("key_level", 32'(key_level), 32'(exp_level));
      check_eq("key_pulse", 32'(key_pulse), 32'(exp_pulse));
      check_eq("dip_sync", 32'(dip_sync), 32'(exp_dip));
      for (int i = 0; i < NK; i++) pcnt[i] += int'(key_pulse[i]);
   endtask

   task automatic clear_pcnt();
      for (int i = 0; i < NK; i++) pcnt[i] = 0;
   endtask

   task automatic hold_key(input int k, input int n, input int exp_cnt, input string tag);
      clear_pcnt();
      key_raw[k] = 1'b1;
      repeat (n) cycle();
      key_raw[k] = 1'b0;
      repeat (12) cycle();
      check_eq(tag, 32'(pcnt[k]), 32'(exp_cnt));
   endtask

   initial begin
      for (int i = 0; i < NK; i++) press_t[i] = 0;
      rst     = 1'b1;
      key_raw = '0;
      dip_raw = '0;
      repeat (2) cycle();
      rst = 1'b0;
      repeat (6) cycle();

      // Clean press, glitch, and auto-repeat versus non-repeating key
      hold_key(1, 30, 1, "clean_press_pulses");
      hold_key(4, 3, 0, "glitch_pulses");
      hold_key(0, 40, 11, "repeat_pulses");

      // Bounce before settling high
      clear_pcnt();
      for (int j = 0; j < 8; j++) begin
         key_raw[3] = (j % 4) < 2;
         cycle();
      end
      key_raw[3] = 1'b1;
      repeat (20) cycle();
      key_raw[3] = 1'b0;
      repeat (12) cycle();
      check_eq("bounce_pulses", 32'(pcnt[3]), 32'd1);

      // Reset while a repeating key is in its hold phase
      key_raw[2] = 1'b1;
      repeat (8) cycle();
      rst = 1'b1;
      cycle();
      check_eq("rst_level", 32'(key_level), 32'd0);
      rst = 1'b0;
      clear_pcnt();
      repeat (25) cycle();
      key_raw[2] = 1'b0;
      repeat (12) cycle();
      check_eq("post_rst_pulses", 32'(pcnt[2]), 32'd6);

      // Simultaneous presses
      clear_pcnt();
      key_raw[0] = 1'b1;
      key_raw[2] = 1'b1;
      repeat (8) cycle();
      key_raw = '0;
      repeat (12) cycle();
      check_eq("simul_k0", 32'(pcnt[0]), 32'd1);
      check_eq("simul_k2", 32'(pcnt[2]), 32'd1);

      // DIP latency
      dip_raw = 16'hA5C3;
      cycle();
      check_eq("dip_1edge", 32'(dip_sync), 32'h0000);
      cycle();
      check_eq("dip_2edge", 32'(dip_sync), 32'hA5C3);
      repeat (3) cycle();

      // Random bouncing, DIP changes and occasional reset
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 29) == 0) key_raw[i] = ~key_raw[i];
         if ($urandom_range(0, 15) == 0) dip_raw = DW'($urandom);
         rst = ($urandom_range(0, 599) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end for the board's push-buttons and DIP switches; produces the clean single-cycle key strobes and synchronized switch word the processor consumes on its key/dip inputs.
- Per key: 2-FF synchronizer, counter debouncer, press-edge pulse generator, optional auto-repeat (used for single-step and load keys).
- Sits between the top-level pins and the processor; one instance per board.

Parameters:
- NUM_KEYS, 5, number of push-buttons.
- DIP_W, 16, DIP switch width.
- DEBOUNCE_CYCLES, 50000, consecutive disagreeing cycles required to accept a new level (>=2).
- REPEAT_MASK, 5'b00101, per-key auto-repeat enable (bit i = key i).
- REPEAT_DELAY, 25000000, cycles from initial press pulse to first repeat pulse (>=2).
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_raw  in  NUM_KEYS  asynchronous button pins, 1 = pressed.
- dip_raw  in  DIP_W  asynchronous switch pins.
- key_pulse  out  NUM_KEYS  one-cycle strobe per accepted press or repeat.
- key_level  out  NUM_KEYS  debounced held level.
- dip_sync  out  DIP_W  2-FF synchronized switch word.

Behaviour:
- Reset: sync flops, stable levels, debounce and repeat counters, key_pulse, key_level, dip_sync all 0. Per-key FSM to IDLE. Reset mid-debounce or mid-repeat discards progress. A key held through reset is treated as a fresh press after reset deasserts.
- Synchronizer: s1 <= raw, s2 <= s1 per bit. dip_sync = s2 of dip path, 2-cycle latency, no debounce.
- Debounce, per key, each edge:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt width = clog2(DEBOUNCE_CYCLES).
- Latency: raw held from sampling edge E0 makes key_level rise after edge E0+DEBOUNCE_CYCLES+1. Release has identical latency.
- Rejection: any disagreement run shorter than DEBOUNCE_CYCLES produces no change and no pulse.
- key_level = stable (registered).
- Per-key FSM (IDLE, HOLD, REPEAT):
  - IDLE: on the edge stable goes 0->1, key_pulse <= 1 for that cycle.
    - Masked key: go to HOLD, rcnt <= 0.
    - Unmasked key: go to HOLD, no repeat counting.
  - HOLD (masked): rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: key_pulse 1 cycle, rcnt <= 0, go to REPEAT. Net result: first repeat pulse is REPEAT_DELAY cycles after the initial pulse.
  - REPEAT: pulse every REPEAT_RATE cycles, same counting scheme.
  - Any state: stable 1->0 -> IDLE, rcnt <= 0, no pulse that cycle. Release never generates a pulse.
- key_pulse is registered; it is never high on two consecutive cycles for one key.
- Keys are fully independent; simultaneous presses produce simultaneous pulses.
- rcnt width = clog2(max(REPEAT_DELAY, REPEAT_RATE)). Counters never wrap: they clear on match.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=5'b00101):
- Clean press: key_raw[1]=1 from edge 0, held 30 cycles -> key_level[1] and key_pulse[1] rise after edge 5. Pulse lasts exactly 1 cycle. No further pulses. Release -> level falls 5 edges after the raw change, no pulse.
- Bounce: key_raw[3] toggles 1,0,1,0 every 2 cycles, then held high -> no pulse during bouncing. Single pulse 5 edges after the final stable sample.
- Glitch: key_raw[4]=1 for 3 cycles -> key_level and key_pulse stay 0.
- Auto-repeat: key_raw[0] held 40 cycles -> initial pulse at cycle P, repeats at P+10, P+13, P+16, ... Release stops pulses within debounce latency. Same hold on key[1] -> only one pulse.
- Reset mid-operation: hold key[2], assert rst one cycle during HOLD -> outputs 0 next cycle. With key still held, a fresh pulse arrives 6 edges after rst deasserts.
- DIP path: dip_raw changes 16'h0000 -> 16'hA5C3 -> dip_sync == 16'hA5C3 exactly 2 edges later. Simultaneous key[0] and key[2] presses -> pulses in the same cycle.
